// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the memory access unit: FSM encoding,
// byte-enable patterns and the timeout counter sizing helper.
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DONE  = 2'd2,
        ABORT = 2'd3
    } state_e;

    localparam logic [3:0] BE_WORD  = 4'hF;
    localparam logic [3:0] BE_BYTE0 = 4'h1;

    localparam int unsigned TIMEOUT_DEFAULT = 15;

    // Counter must be able to hold the value TIMEOUT itself.
    function automatic int unsigned cnt_width(input int unsigned timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/mem_access_unit_byte_lane.sv
// Byte lane steering for a 32-bit, four-lane bus: write replication,
// byte-enable generation and read lane extraction with zero-extension.
module byte_lane_unit
    import mem_access_unit_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic        byte_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    always_comb begin
        be_o    = BE_WORD;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
        if (byte_i) begin
            be_o    = BE_BYTE0 << addr_lo_i;
            wdata_o = {4{wdata_i[7:0]}};
            rdata_o = {24'b0, rdata_i[{addr_lo_i, 3'b000} +: 8]};
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Single-transaction memory access engine: req/ack handshake with a bounded
// wait-state timeout, misalignment abort and zero-extended byte reads.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] in_address,
    input  logic              start,
    input  logic              write,
    input  logic              byte_access,
    input  logic [DATA_W-1:0] in_wdata,
    output logic              busy,
    output logic              done,
    output logic              abort,
    output logic [DATA_W-1:0] out_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam int unsigned CNT_W = cnt_width(TIMEOUT);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic                byte_q, byte_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                abort_q, abort_d;
    logic                req_q, req_d;

    logic [3:0]          lane_be;
    logic [DATA_W-1:0]   lane_wdata;
    logic [DATA_W-1:0]   lane_rdata;

    byte_lane_unit u_byte_lane (
        .addr_lo_i (addr_q[1:0]),
        .byte_i    (byte_q),
        .wdata_i   (wdata_q),
        .rdata_i   (mem_rdata),
        .be_o      (lane_be),
        .wdata_o   (lane_wdata),
        .rdata_o   (lane_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        byte_d  = byte_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = in_address;
                    we_d    = write;
                    byte_d  = byte_access;
                    wdata_d = in_wdata;
                    cnt_d   = '0;
                    state_d = (!byte_access && in_address[1:0] != 2'b00) ? ABORT : REQ;
                end
            end
            REQ: begin
                // An ack in the expiry cycle still completes the access.
                if (mem_ack) begin
                    state_d = DONE;
                    if (!we_q) rdata_d = lane_rdata;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_W'(TIMEOUT)) state_d = ABORT;
                end
            end
            DONE:  state_d = IDLE;
            ABORT: state_d = IDLE;
        endcase
        busy_d  = (state_d != IDLE);
        req_d   = (state_d == REQ);
        done_d  = (state_d == DONE);
        abort_d = (state_d == ABORT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            byte_q  <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            byte_q  <= byte_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            abort_q <= abort_d;
            req_q   <= req_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign abort     = abort_q;
    assign out_rdata = rdata_q;
    assign mem_addr  = addr_q;
    assign mem_req   = req_q;
    // Bus qualifiers are only driven while a request is outstanding.
    assign mem_we    = req_q & we_q;
    assign mem_be    = req_q ? lane_be : 4'b0000;
    assign mem_wdata = req_q ? lane_wdata : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed plan items followed by
// randomized transactions checked against a transaction-level model.
module tb_mem_access_unit;

    localparam int unsigned TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_address;
    logic        start;
    logic        write;
    logic        byte_access;
    logic [31:0] in_wdata;
    logic        busy;
    logic        done;
    logic        abort;
    logic [31:0] out_rdata;
    logic [31:0] mem_addr;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_rdata = 32'h0;

    always #5 clk = ~clk;

    mem_access_unit #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_address  (in_address),
        .start       (start),
        .write       (write),
        .byte_access (byte_access),
        .in_wdata    (in_wdata),
        .busy        (busy),
        .done        (done),
        .abort       (abort),
        .out_rdata   (out_rdata),
        .mem_addr    (mem_addr),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_be      (mem_be),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ack_cycle: REQ cycle (1-based) in which mem_ack is driven; beyond TIMEOUT means never.
    task automatic run_txn(input logic [31:0] addr, input bit wr, input bit byt,
                           input logic [31:0] wd, input int ack_cycle,
                           input logic [31:0] rd, input bit poke);
        logic [1:0]  a;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        logic [31:0] exp_rd;
        bit          mis;
        bit          exp_done;
        bit          stable;
        int          exp_req;
        int          req_cnt;
        a        = addr[1:0];
        mis      = !byt && (a != 2'b00);
        exp_be   = byt ? (4'b0001 << a) : 4'hF;
        exp_wd   = byt ? {4{wd[7:0]}} : wd;
        exp_rd   = byt ? ((rd >> (8 * a)) & 32'hFF) : rd;
        exp_done = (ack_cycle <= TIMEOUT);
        exp_req  = exp_done ? ack_cycle : TIMEOUT;

        start = 1'b1; in_address = addr; write = wr; byte_access = byt; in_wdata = wd;
        mem_ack = 1'b0;
        step();
        start = 1'b0; in_address = $urandom; in_wdata = $urandom;
        write = $urandom_range(0, 1); byte_access = $urandom_range(0, 1);

        if (mis) begin
            check("mis_abort", abort, 1'b1);
            check("mis_req", mem_req, 1'b0);
            check("mis_busy", busy, 1'b1);
            step();
            check("mis_abort_clear", abort, 1'b0);
            check("mis_busy_clear", busy, 1'b0);
            check("mis_rdata", out_rdata, model_rdata);
            return;
        end

        req_cnt = 0;
        stable  = 1'b1;
        while (mem_req === 1'b1 && req_cnt < 40) begin
            req_cnt++;
            if (mem_addr !== addr || mem_be !== exp_be || mem_we !== wr ||
                mem_wdata !== exp_wd || busy !== 1'b1 || done !== 1'b0 || abort !== 1'b0)
                stable = 1'b0;
            mem_ack   = (req_cnt == ack_cycle);
            mem_rdata = mem_ack ? rd : $urandom;
            start     = poke && (req_cnt == 1);
            if (start) in_address = addr ^ 32'h40;
            step();
        end
        mem_ack = 1'b0; start = 1'b0;
        if (exp_done && !wr) model_rdata = exp_rd;

        check("req_cycles", req_cnt, exp_req);
        check("bus_stable", stable, 1'b1);
        check("done_pulse", done, exp_done);
        check("abort_pulse", abort, !exp_done);
        check("req_dropped", mem_req, 1'b0);
        check("busy_end", busy, 1'b1);
        check("out_rdata", out_rdata, model_rdata);
        step();
        check("busy_idle", busy, 1'b0);
        check("done_clear", done, 1'b0);
        check("abort_clear", abort, 1'b0);
        check("req_idle", mem_req, 1'b0);
    endtask

    initial begin
        logic [31:0] addr;
        bit          byt;
        rst = 1'b1; start = 1'b0; write = 1'b0; byte_access = 1'b0;
        in_address = 32'h0; in_wdata = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_req", mem_req, 1'b0);
        check("rst_rdata", out_rdata, 32'h0);
        check("rst_be", mem_be, 4'h0);
        check("rst_addr", mem_addr, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        step();

        // Plan items: word read zero-wait, byte write two waits, byte read lane 2.
        run_txn(32'h100, 1'b0, 1'b0, 32'h0, 1, 32'hDEADBEEF, 1'b0);
        run_txn(32'h203, 1'b1, 1'b1, 32'h000000A5, 3, 32'h0, 1'b0);
        run_txn(32'h402, 1'b0, 1'b1, 32'h0, 1, 32'h11223344, 1'b0);
        run_txn(32'h101, 1'b0, 1'b0, 32'h0, 1, 32'h0, 1'b0);
        // Timeout expiry, then ack landing in the final allowed cycle.
        run_txn(32'h600, 1'b0, 1'b0, 32'h0, TIMEOUT + 1, 32'h12345678, 1'b0);
        run_txn(32'h604, 1'b0, 1'b0, 32'h0, TIMEOUT, 32'hCAFEF00D, 1'b0);

        // Asynchronous reset while in REQ.
        start = 1'b1; in_address = 32'h500; write = 1'b0; byte_access = 1'b0;
        step();
        start = 1'b0;
        step(); step();
        check("pre_rst_req", mem_req, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("arst_req", mem_req, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_rdata", out_rdata, 32'h0);
        check("arst_done", done, 1'b0);
        check("arst_abort", abort, 1'b0);
        model_rdata = 32'h0;
        @(negedge clk);
        rst = 1'b0;
        step();
        run_txn(32'h700, 1'b0, 1'b0, 32'h0, 3, 32'h0BADF00D, 1'b1);

        for (int i = 0; i < 40; i++) begin
            addr = $urandom;
            byt  = $urandom_range(0, 1);
            if (!byt && $urandom_range(0, 1)) addr[1:0] = 2'b00;
            run_txn(addr, $urandom_range(0, 1), byt, $urandom, $urandom_range(1, 18),
                    $urandom, $urandom_range(0, 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
